// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg: shared constants, FSM encodings and key-map helpers for the keypad scanner
package keypad_scan_pkg;
  localparam logic [3:0] COL_IDLE = 4'b1110;
  localparam int KEY_W = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_WAIT_REL = 2'd2;
  function automatic logic single_key(input logic [15:0] m);
    return (m != '0) && ((m & (m - 16'd1)) == '0);
  endfunction
  function automatic logic [KEY_W-1:0] key_index(input logic [15:0] m);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) if (m[i]) idx = KEY_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a 16-key map once it has been identical for DEBOUNCE_SCANS full scans
module keypad_debounce #(
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] key_map,
  input  logic        scan_done,
  output logic [15:0] debounced,
  output logic        accept
);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  logic [15:0]   prev;
  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          reach;
  always_comb begin
    cnt_nxt = key_map != prev ? CW'(1)
            : stable_cnt == CW'(DEBOUNCE_SCANS) ? stable_cnt : stable_cnt + 1'b1;
    reach   = cnt_nxt == CW'(DEBOUNCE_SCANS) && (stable_cnt != CW'(DEBOUNCE_SCANS) || key_map != prev);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      stable_cnt <= '0;
      debounced  <= '0;
      accept     <= 1'b0;
    end else begin
      accept <= 1'b0;
      if (scan_done) begin
        prev       <= key_map;
        stable_cnt <= cnt_nxt;
        if (reach && key_map != debounced) begin
          debounced <= key_map;
          accept    <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with row sync, column ring, debounce and single-key FSM
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV       = 50_000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       key_row,
  output logic [3:0]       key_col,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  output logic             key_pressed
);
  localparam int TW = $clog2(SCAN_DIV);
  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  logic [TW-1:0] col_timer;
  logic [1:0]    col_idx;
  logic [15:0]   snapshot;
  logic [15:0]   debounced;
  logic          scan_done;
  logic          accept;
  logic          tick;
  logic [1:0]    state;
  assign tick = col_timer == TW'(SCAN_DIV - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1    <= '1;
      row_s2    <= '1;
      col_timer <= '0;
      col_idx   <= '0;
      key_col   <= COL_IDLE;
      snapshot  <= '0;
      scan_done <= 1'b0;
    end else begin
      row_s1    <= key_row;
      row_s2    <= row_s1;
      col_timer <= tick ? '0 : col_timer + 1'b1;
      scan_done <= tick && col_idx == 2'd3;
      if (tick) begin
        for (int r = 0; r < 4; r++) snapshot[r*4+col_idx] <= ~row_s2[r];
        col_idx <= col_idx + 2'd1;
        key_col <= ~(4'b0001 << (col_idx + 2'd1));
      end
    end
  end
  keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_map   (snapshot),
    .scan_done (scan_done),
    .debounced (debounced),
    .accept    (accept)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_pressed <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (accept && state == S_IDLE && single_key(debounced)) begin
        key_code    <= key_index(debounced);
        key_valid   <= 1'b1;
        key_pressed <= 1'b1;
        state       <= S_PRESSED;
      end else if (accept) begin
        key_pressed <= 1'b0;
        state       <= debounced == '0 ? S_IDLE : S_WAIT_REL;
      end
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: drives a modelled 4x4 keypad and checks accepted keys against press/release intent
module tb_keypad_scan;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_pressed;
  logic [15:0] keys = '0;
  logic        prev_valid = 1'b0;
  logic [3:0]  got[$];
  int          vectors = 0;
  int          miscompares = 0;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_row     (key_row),
    .key_col     (key_col),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_pressed (key_pressed)
  );

  always #5 clk = ~clk;

  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) prev_valid = 1'b0;
    else begin
      vectors++;
      if ($countones(~key_col) != 1) begin
        miscompares++;
        $display("FAIL col_onehot: key_col=%b, required exactly one low bit", key_col);
      end
      if (key_valid && prev_valid) begin
        miscompares++;
        $display("FAIL valid_width: key_valid high two cycles in a row, required one-cycle pulse");
      end
      if (key_valid) got.push_back(key_code);
      prev_valid = key_valid;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_one(input string name, input logic [3:0] code);
    vectors++;
    if (got.size() !== 1 || got[0] !== code) begin
      miscompares++;
      $display("FAIL %s: %0d pulses first code %0d, required 1 pulse code %0d", name, got.size(),
               got.size() > 0 ? got[0] : 4'd0, code);
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    cyc(3);
    vectors++;
    if ({key_col, key_valid, key_code, key_pressed} !== {4'b1110, 1'b0, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: col=%b valid=%b code=%0d pressed=%b, required 1110 0 0 0",
               key_col, key_valid, key_code, key_pressed);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      logic [3:0] exp_col;
      @(negedge clk);
      exp_col = ~(4'b0001 << ((n / 4) % 4));
      vectors++;
      if (key_col !== exp_col || key_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL col_scan n=%0d: col=%b valid=%b, required col=%b valid=0", n, key_col, key_valid, exp_col);
      end
    end
  endtask

  task automatic test_press;
    got.delete();
    keys = 16'(1) << 6;
    cyc(200);
    check_one("press_6", 4'd6);
    vectors++;
    if (key_pressed !== 1'b1) begin
      miscompares++;
      $display("FAIL press_level: key_pressed=%b, required 1", key_pressed);
    end
    got.delete();
    keys = '0;
    cyc(64);
    vectors++;
    if (key_pressed !== 1'b0) begin
      miscompares++;
      $display("FAIL release_level: key_pressed=%b 64 clk after release, required 0", key_pressed);
    end
    cyc(100);
    vectors++;
    if (got.size() !== 0 || key_code !== 4'd6) begin
      miscompares++;
      $display("FAIL release_quiet: %0d pulses code=%0d, required 0 pulses code 6", got.size(), key_code);
    end
  endtask

  task automatic test_bounce;
    int toggles;
    toggles = 4 + int'($urandom_range(0, 3));
    cyc(int'($urandom_range(0, 15)));
    got.delete();
    for (int i = 0; i < toggles; i++) begin
      keys[8] = ~keys[8];
      cyc(16);
    end
    vectors++;
    if (got.size() !== 0) begin
      miscompares++;
      $display("FAIL bounce_quiet: %0d pulses during bounce, required 0", got.size());
    end
    keys = 16'(1) << 8;
    cyc(200);
    check_one("bounce_settle_8", 4'd8);
    keys = '0;
    cyc(100);
  endtask

  task automatic test_multi;
    got.delete();
    keys = 16'h8001;
    cyc(150);
    vectors++;
    if (got.size() !== 0 || key_pressed !== 1'b0) begin
      miscompares++;
      $display("FAIL two_keys: %0d pulses pressed=%b, required 0 pulses pressed 0", got.size(), key_pressed);
    end
    keys = 16'h0001;
    cyc(150);
    vectors++;
    if (got.size() !== 0) begin
      miscompares++;
      $display("FAIL partial_release: %0d pulses, required 0", got.size());
    end
    keys = '0;
    cyc(100);
    keys = 16'(1) << 5;
    cyc(150);
    check_one("after_release_5", 4'd5);
    keys = '0;
    cyc(100);
    got.delete();
    keys = 16'(1) << 2;
    cyc(150);
    check_one("held_2", 4'd2);
    keys[11] = 1'b1;
    cyc(150);
    vectors++;
    if (key_pressed !== 1'b0 || got.size() !== 1) begin
      miscompares++;
      $display("FAIL second_key: pressed=%b pulses=%0d, required pressed 0 pulses 1", key_pressed, got.size());
    end
    keys[11] = 1'b0;
    cyc(150);
    vectors++;
    if (got.size() !== 1) begin
      miscompares++;
      $display("FAIL wait_release: pulses=%0d, required 1", got.size());
    end
    keys = '0;
    cyc(100);
  endtask

  task automatic test_reset_mid;
    got.delete();
    keys = 16'(1) << 3;
    cyc(100);
    check_one("pre_reset_3", 4'd3);
    cyc(int'($urandom_range(1, 15)));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({key_col, key_valid, key_code, key_pressed} !== {4'b1110, 1'b0, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: col=%b valid=%b code=%0d pressed=%b, required 1110 0 0 0",
               key_col, key_valid, key_code, key_pressed);
    end
    cyc(3);
    got.delete();
    rst_n = 1'b1;
    cyc(200);
    check_one("post_reset_3", 4'd3);
    keys = '0;
    cyc(100);
  endtask

  task automatic test_back_to_back;
    got.delete();
    keys = 16'(1) << 9;
    cyc(120);
    keys = '0;
    cyc(80);
    keys = 16'(1) << 10;
    cyc(120);
    keys = '0;
    cyc(80);
    vectors++;
    if (got.size() !== 2 || got[0] !== 4'd9 || got[1] !== 4'd10 || key_code !== 4'd10) begin
      miscompares++;
      $display("FAIL back_to_back: pulses=%0d code=%0d, required codes 9,10 and key_code 10", got.size(), key_code);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] k;
      k = 4'($urandom_range(0, 15));
      got.delete();
      keys = 16'(1) << k;
      cyc(int'($urandom_range(80, 150)));
      check_one("random_press", k);
      vectors++;
      if (key_pressed !== 1'b1) begin
        miscompares++;
        $display("FAIL random_held key=%0d: key_pressed=%b, required 1", k, key_pressed);
      end
      keys = '0;
      cyc(int'($urandom_range(70, 120)));
      vectors++;
      if (key_pressed !== 1'b0 || got.size() !== 1 || key_code !== k) begin
        miscompares++;
        $display("FAIL random_release key=%0d: pressed=%b pulses=%0d code=%0d, required 0 1 %0d",
                 k, key_pressed, got.size(), key_code, k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_multi();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
